// File: rtl/line_encoder_serial.sv
// Serial priority encoder: captures a multi-hot request vector and emits the
// index of each set line, lowest first, over a valid/ready handshake.
module line_encoder_serial #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] D,
    input  logic         load,
    output logic [W-1:0] A,
    output logic         valid,
    input  logic         ready,
    output logic         busy,
    output logic         done,
    output logic         overrun
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [N-1:0]   pending;
    logic [N-1:0]   pending_next;
    logic [N-1:0]   remainder;
    logic [N-1:0]   accepted_bit;
    logic [W-1:0]   a_next;
    logic           done_next;
    logic           overrun_next;

    // Scanning from the top down lets the lowest set bit overwrite the result last.
    function automatic logic [W-1:0] lowest_index(input logic [N-1:0] vec);
        lowest_index = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                lowest_index = W'(i);
            end
        end
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pending <= '0;
            A       <= '0;
            done    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state   <= state_next;
            pending <= pending_next;
            A       <= a_next;
            done    <= done_next;
            overrun <= overrun_next;
        end
    end

    assign accepted_bit = {{(N-1){1'b0}}, 1'b1} << A;
    assign remainder    = pending & ~accepted_bit;

    // The next index is derived from the next pending vector so A stays registered.
    always_comb begin
        state_next   = state;
        pending_next = pending;
        a_next       = A;
        done_next    = 1'b0;
        overrun_next = 1'b0;
        case (state)
            IDLE: begin
                if (load) begin
                    if (D != '0) begin
                        pending_next = D;
                        a_next       = lowest_index(D);
                        state_next   = BUSY;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            BUSY: begin
                overrun_next = load;
                if (ready) begin
                    pending_next = remainder;
                    if (remainder != '0) begin
                        a_next = lowest_index(remainder);
                    end else begin
                        a_next     = '0;
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end
            end
            default: begin
                state_next   = IDLE;
                pending_next = '0;
                a_next       = '0;
            end
        endcase
    end

    always_comb begin
        valid = (state == BUSY);
        busy  = (state == BUSY);
    end

endmodule

// File: tb/tb_line_encoder_serial.sv
// Directed bench for line_encoder_serial: a 4-line and an 8-line instance
// driven from one initial block, outputs sampled 1 time unit after each edge.
module tb_line_encoder_serial;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic [3:0] d4 = '0;
    logic       load4 = 1'b0;
    logic       ready4 = 1'b0;
    logic [1:0] a4;
    logic       valid4, busy4, done4, overrun4;

    logic [7:0] d8 = '0;
    logic       load8 = 1'b0;
    logic       ready8 = 1'b0;
    logic [2:0] a8;
    logic       valid8, busy8, done8, overrun8;

    int checks = 0;
    int errors = 0;

    // Observed fields packed as {A, valid, busy, done, overrun}.
    logic [5:0] obs4;
    logic [6:0] obs8;
    assign obs4 = {a4, valid4, busy4, done4, overrun4};
    assign obs8 = {a8, valid8, busy8, done8, overrun8};

    line_encoder_serial #(.N(4), .W(2)) dut4 (
        .clk(clk), .rst(rst), .D(d4), .load(load4), .A(a4), .valid(valid4),
        .ready(ready4), .busy(busy4), .done(done4), .overrun(overrun4)
    );

    line_encoder_serial #(.N(8), .W(3)) dut8 (
        .clk(clk), .rst(rst), .D(d8), .load(load8), .A(a8), .valid(valid8),
        .ready(ready8), .busy(busy8), .done(done8), .overrun(overrun8)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++;
        if (obs4 !== 6'b00_0_0_0_0) begin
            errors++;
            $display("[TB] FAIL reset4: got %b expected %b (A,valid,busy,done,overrun)", obs4, 6'b00_0_0_0_0);
        end
        checks++;
        if (obs8 !== 7'b000_0_0_0_0) begin
            errors++;
            $display("[TB] FAIL reset8: got %b expected %b (A,valid,busy,done,overrun)", obs8, 7'b000_0_0_0_0);
        end
    endtask

    task automatic test_drain();
        logic [5:0] exp_seq [4];
        exp_seq[0] = 6'b00_1_1_0_0;
        exp_seq[1] = 6'b01_1_1_0_0;
        exp_seq[2] = 6'b11_1_1_0_0;
        exp_seq[3] = 6'b00_0_0_1_0;
        ready4 = 1'b1;
        d4 = 4'b1011;
        load4 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            load4 = 1'b0;
            checks++;
            if (obs4 !== exp_seq[i]) begin
                errors++;
                $display("[TB] FAIL drain_1011[%0d]: got %b expected %b", i, obs4, exp_seq[i]);
            end
        end
        step();
        ready4 = 1'b0;
        checks++;
        if (obs4 !== 6'b00_0_0_0_0) begin
            errors++;
            $display("[TB] FAIL drain_done_once: got %b expected %b", obs4, 6'b00_0_0_0_0);
        end
    endtask

    task automatic test_stall();
        ready4 = 1'b0;
        d4 = 4'b0110;
        load4 = 1'b1;
        step();
        load4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs4 !== 6'b01_1_1_0_0) begin
                errors++;
                $display("[TB] FAIL stall_hold[%0d]: got %b expected %b", i, obs4, 6'b01_1_1_0_0);
            end
            if (i < 3) step();
        end
        ready4 = 1'b1;
        step();
        checks++;
        if (obs4 !== 6'b10_1_1_0_0) begin
            errors++;
            $display("[TB] FAIL stall_next: got %b expected %b", obs4, 6'b10_1_1_0_0);
        end
        step();
        ready4 = 1'b0;
        checks++;
        if (obs4 !== 6'b00_0_0_1_0) begin
            errors++;
            $display("[TB] FAIL stall_done: got %b expected %b", obs4, 6'b00_0_0_1_0);
        end
        step();
    endtask

    task automatic test_empty_load();
        ready4 = 1'b1;
        d4 = 4'b0000;
        load4 = 1'b1;
        step();
        load4 = 1'b0;
        checks++;
        if (obs4 !== 6'b00_0_0_1_0) begin
            errors++;
            $display("[TB] FAIL empty_done: got %b expected %b", obs4, 6'b00_0_0_1_0);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (obs4 !== 6'b00_0_0_0_0) begin
                errors++;
                $display("[TB] FAIL empty_quiet[%0d]: got %b expected %b", i, obs4, 6'b00_0_0_0_0);
            end
        end
        ready4 = 1'b0;
    endtask

    task automatic test_overrun();
        ready4 = 1'b0;
        d4 = 4'b1000;
        load4 = 1'b1;
        step();
        d4 = 4'b0001;
        checks++;
        if (obs4 !== 6'b11_1_1_0_0) begin
            errors++;
            $display("[TB] FAIL ovr_load: got %b expected %b", obs4, 6'b11_1_1_0_0);
        end
        step();
        load4 = 1'b0;
        checks++;
        if (obs4 !== 6'b11_1_1_0_1) begin
            errors++;
            $display("[TB] FAIL ovr_pulse: got %b expected %b", obs4, 6'b11_1_1_0_1);
        end
        step();
        checks++;
        if (obs4 !== 6'b11_1_1_0_0) begin
            errors++;
            $display("[TB] FAIL ovr_clear: got %b expected %b", obs4, 6'b11_1_1_0_0);
        end
        ready4 = 1'b1;
        step();
        checks++;
        if (obs4 !== 6'b00_0_0_1_0) begin
            errors++;
            $display("[TB] FAIL ovr_done: got %b expected %b", obs4, 6'b00_0_0_1_0);
        end
        step();
        ready4 = 1'b0;
        checks++;
        if (obs4 !== 6'b00_0_0_0_0) begin
            errors++;
            $display("[TB] FAIL ovr_ignored_d: got %b expected %b", obs4, 6'b00_0_0_0_0);
        end
    endtask

    task automatic test_back_to_back();
        ready4 = 1'b1;
        d4 = 4'b0001;
        load4 = 1'b1;
        step();
        d4 = 4'b1111;
        checks++;
        if (obs4 !== 6'b00_1_1_0_0) begin
            errors++;
            $display("[TB] FAIL b2b_load: got %b expected %b", obs4, 6'b00_1_1_0_0);
        end
        step();
        checks++;
        if (obs4 !== 6'b00_0_0_1_1) begin
            errors++;
            $display("[TB] FAIL b2b_final_accept_overrun: got %b expected %b", obs4, 6'b00_0_0_1_1);
        end
        d4 = 4'b0010;
        ready4 = 1'b0;
        step();
        load4 = 1'b0;
        checks++;
        if (obs4 !== 6'b01_1_1_0_0) begin
            errors++;
            $display("[TB] FAIL b2b_reload_after_done: got %b expected %b", obs4, 6'b01_1_1_0_0);
        end
        ready4 = 1'b1;
        step();
        ready4 = 1'b0;
        checks++;
        if (obs4 !== 6'b00_0_0_1_0) begin
            errors++;
            $display("[TB] FAIL b2b_done: got %b expected %b", obs4, 6'b00_0_0_1_0);
        end
        step();
    endtask

    task automatic test_reset_mid_drain();
        ready4 = 1'b1;
        d4 = 4'b1111;
        load4 = 1'b1;
        step();
        load4 = 1'b0;
        step();
        checks++;
        if (obs4 !== 6'b01_1_1_0_0) begin
            errors++;
            $display("[TB] FAIL mid_accept0: got %b expected %b", obs4, 6'b01_1_1_0_0);
        end
        ready4 = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (obs4 !== 6'b00_0_0_0_0) begin
            errors++;
            $display("[TB] FAIL mid_reset: got %b expected %b", obs4, 6'b00_0_0_0_0);
        end
        step();
        checks++;
        if (obs4 !== 6'b00_0_0_0_0) begin
            errors++;
            $display("[TB] FAIL mid_no_done: got %b expected %b", obs4, 6'b00_0_0_0_0);
        end
        d4 = 4'b0100;
        load4 = 1'b1;
        step();
        load4 = 1'b0;
        checks++;
        if (obs4 !== 6'b10_1_1_0_0) begin
            errors++;
            $display("[TB] FAIL mid_fresh_load: got %b expected %b", obs4, 6'b10_1_1_0_0);
        end
        ready4 = 1'b1;
        step();
        ready4 = 1'b0;
        checks++;
        if (obs4 !== 6'b00_0_0_1_0) begin
            errors++;
            $display("[TB] FAIL mid_fresh_done: got %b expected %b", obs4, 6'b00_0_0_1_0);
        end
        step();
    endtask

    task automatic test_wide();
        logic       ready_seq [4];
        logic [6:0] exp_seq [4];
        ready_seq[0] = 1'b1; exp_seq[0] = 7'b000_1_1_0_0;
        ready_seq[1] = 1'b0; exp_seq[1] = 7'b111_1_1_0_0;
        ready_seq[2] = 1'b1; exp_seq[2] = 7'b111_1_1_0_0;
        ready_seq[3] = 1'b0; exp_seq[3] = 7'b000_0_0_1_0;
        d8 = 8'b1000_0001;
        load8 = 1'b1;
        ready8 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            load8 = 1'b0;
            ready8 = ready_seq[i];
            checks++;
            if (obs8 !== exp_seq[i]) begin
                errors++;
                $display("[TB] FAIL wide8[%0d]: got %b expected %b", i, obs8, exp_seq[i]);
            end
        end
        step();
        checks++;
        if (obs8 !== 7'b000_0_0_0_0) begin
            errors++;
            $display("[TB] FAIL wide8_idle: got %b expected %b", obs8, 7'b000_0_0_0_0);
        end
    endtask

    initial begin
        test_reset();
        test_drain();
        test_stall();
        test_empty_load();
        test_overrun();
        test_back_to_back();
        test_reset_mid_drain();
        test_wide();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
